vec_inst_queue: RTL
===================

// Module: vec_inst_queue
// PURPOSE
// - Decoupling buffer between scalar core and vec_decode: captures each vector instruction with its rs1/rs2 operands.
// - Presents the oldest entry to vec_decode, first-word-fall-through.
// - Serialises vector configuration (vsetvli/vsetivli/vsetvl): after a CONF instruction issues, no further
//   entry issues until the CSR stage returns cfg_done, so later instructions always decode under the updated vl/vtype.
// PARAMETERS
// - XLEN   32  instruction and scalar operand width; matches `XLEN in vec_de_csr_defs.svh
// - DEPTH  4   number of entries; power of two, >= 2
// PORTS
// - clk        in   1                    clock; all state updates on rising edge
// - reset      in   1                    synchronous, active-high reset
// - flush      in   1                    discard all entries; scalar pipeline redirect
// - in_valid   in   1                    scalar core offers an instruction
// - in_ready   out  1                    queue can accept; = !full
// - in_inst    in   XLEN                 vector instruction word
// - in_rs1     in   XLEN                 rs1_data captured at dispatch
// - in_rs2     in   XLEN                 rs2_data captured at dispatch
// - out_valid  out  1                    head entry is available to vec_decode
// - out_ready  in   1                    vec_decode consumes head
// - out_inst   out  XLEN                 head vec_inst
// - out_rs1    out  XLEN                 head rs1_data
// - out_rs2    out  XLEN                 head rs2_data
// - cfg_done   in   1                    one-cycle pulse from CSR stage: vl/vtype write complete
// - count      out  $clog2(DEPTH)+1      number of valid entries
// - full       out  1                    count == DEPTH
// - empty      out  1                    count == 0
// BEHAVIOUR
// - Reset and flush values: rd_ptr=0, wr_ptr=0, count=0, empty=1, full=0, in_ready=1, out_valid=0, FSM=RUN.
//   Storage contents are not reset.
// - Reset takes priority over flush. Flush takes priority over enqueue and dequeue in the same cycle:
//   a handshake in that cycle is dropped.
// - Enqueue on in_valid && in_ready: write {in_inst,in_rs1,in_rs2} at wr_ptr, then wr_ptr++ (mod DEPTH).
// - Dequeue on out_valid && out_ready: rd_ptr++ (mod DEPTH).
// - out_inst/out_rs1/out_rs2 = storage[rd_ptr]. These outputs are don't-care while out_valid=0.
// - Latency: enqueue into an empty queue at cycle N makes out_valid=1 at N+1. There is no same-cycle bypass.
// - Enqueue and dequeue in the same cycle leave count unchanged.
// - When full, in_ready=0 even if a dequeue occurs that cycle. No enqueue happens when full.
// - Pointers wrap from DEPTH-1 to 0. full/empty derive from count, not from pointer compare.
// - CONF detection on the head entry: out_inst[6:0]==V_ARITH (7'h57) && out_inst[14:12]==CONF (3'b111).
// - FSM, two states:
//   - RUN: out_valid = !empty. A dequeue of a CONF entry moves to WAIT_CFG at the next edge.
//   - WAIT_CFG: out_valid forced 0. Enqueue continues normally. cfg_done=1 moves to RUN at the next edge,
//     so the next head can issue one cycle after cfg_done.
//   - cfg_done in RUN is ignored.
//   - cfg_done arriving in the same cycle as the CONF dequeue is ignored; WAIT_CFG is still entered.
//   - flush or reset in WAIT_CFG returns to RUN.
// - Non-CONF entries never stall; back-to-back dequeue at one entry per cycle.
// STRUCTURE
// - Package vec_de_csr_defs.svh: reuse v_opcode_e (V_ARITH) and v_func3_e (CONF). Add typedef vec_iq_entry_t
//   {inst, rs1, rs2} and typedef enum vec_iq_state_e {IQ_RUN, IQ_WAIT_CFG}.
// - One sub-module, vec_iq_fifo: storage array plus pointers/count/full/empty. The top level holds the CONF
//   FSM and the out_valid gating. Target 150-250 lines total.
// TESTING
// - Fill/drain: DEPTH=4, out_ready=0, enqueue 5 times (inst=0x02008057+i) -> 4 accepted, full=1, in_ready=0
//   on the 5th. Then out_ready=1 -> 4 entries out in order, empty=1.
// - Wrap and simultaneous: hold count=2 while enqueue and dequeue together for 10 cycles -> count stays 2,
//   FIFO order preserved across pointer wrap.
// - CONF stall: enqueue vsetvli 0x0D0572D7 then vadd.vv 0x022180D7, out_ready=1 -> vsetvli issues.
//   out_valid=0 until cfg_done is pulsed at cycle N; vadd out_valid=1 at N+1.
// - cfg_done edge cases: cfg_done in RUN has no effect. cfg_done coinciding with the CONF dequeue -> queue
//   still waits for a later cfg_done.
// - Flush: 3 entries in WAIT_CFG plus flush with in_valid=1 -> next cycle count=0, empty=1, FSM=RUN,
//   flushing-cycle instruction not stored.
// - Reset mid-operation: reset with queue full -> next cycle count=0, in_ready=1, out_valid=0.

Source files
------------

// File: rtl/vec_inst_queue_pkg.sv
// Shared types for the vector instruction queue: opcode/func3 codes used for
// CONF detection, the stored entry layout and the issue-gating FSM states.
package vec_inst_queue_pkg;

    localparam int VQ_XLEN = 32;

    typedef enum logic [6:0] {
        V_ARITH = 7'h57
    } v_opcode_e;

    typedef enum logic [2:0] {
        CONF = 3'b111
    } v_func3_e;

    typedef struct packed {
        logic [VQ_XLEN-1:0] inst;
        logic [VQ_XLEN-1:0] rs1;
        logic [VQ_XLEN-1:0] rs2;
    } vec_iq_entry_t;

    typedef enum logic {
        IQ_RUN      = 1'b0,
        IQ_WAIT_CFG = 1'b1
    } vec_iq_state_e;

endpackage

// File: rtl/vec_iq_fifo.sv
// Circular-buffer FIFO with first-word-fall-through read port; full/empty are
// derived from the occupancy count so pointer equality is never ambiguous.
module vec_iq_fifo #(
    parameter int W     = 96,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       flush,
    input  logic                       wr_en,
    input  logic [W-1:0]               wr_data,
    input  logic                       rd_en,
    output logic [W-1:0]               rd_data,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       full,
    output logic                       empty
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [W-1:0]  mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          do_wr;
    logic          do_rd;

    assign full  = (count_q == CW'(DEPTH));
    assign empty = (count_q == '0);
    assign count = count_q;

    // Flush drops any handshake in its cycle, including a write to storage.
    assign do_wr = wr_en && !full && !flush;
    assign do_rd = rd_en && !empty && !flush;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_wr) begin
                wr_ptr_d = (wr_ptr_q == PW'(DEPTH - 1)) ? '0 : wr_ptr_q + PW'(1);
            end
            if (do_rd) begin
                rd_ptr_d = (rd_ptr_q == PW'(DEPTH - 1)) ? '0 : rd_ptr_q + PW'(1);
            end
            case ({do_wr, do_rd})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem_q[wr_ptr_q] <= wr_data;
        end
    end

    assign rd_data = mem_q[rd_ptr_q];

endmodule

// File: rtl/vec_inst_queue.sv
// Decoupling queue between the scalar core and vec_decode; holds issue after a
// vector-config instruction until the CSR stage reports the new vl/vtype.
//
// Handshakes: a transfer happens on a rising edge where valid && ready are both
// high; valid does not depend on ready, and flush cancels any transfer that cycle.
module vec_inst_queue
    import vec_inst_queue_pkg::*;
#(
    parameter int XLEN  = VQ_XLEN,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   flush,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [XLEN-1:0]        in_inst,
    input  logic [XLEN-1:0]        in_rs1,
    input  logic [XLEN-1:0]        in_rs2,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [XLEN-1:0]        out_inst,
    output logic [XLEN-1:0]        out_rs1,
    output logic [XLEN-1:0]        out_rs2,
    input  logic                   cfg_done,
    output logic [$clog2(DEPTH):0] count,
    output logic                   full,
    output logic                   empty,
    output vec_iq_state_e          dbg_state
);

    localparam int EW = 3 * XLEN;

    vec_iq_state_e state_q, state_d;
    logic [EW-1:0] rd_data;
    logic          head_is_conf;
    logic          deq;

    vec_iq_fifo #(
        .W     (EW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .flush   (flush),
        .wr_en   (in_valid),
        .wr_data ({in_inst, in_rs1, in_rs2}),
        .rd_en   (deq),
        .rd_data (rd_data),
        .count   (count),
        .full    (full),
        .empty   (empty)
    );

    assign in_ready = !full;
    assign out_inst = rd_data[EW-1 -: XLEN];
    assign out_rs1  = rd_data[2*XLEN-1 -: XLEN];
    assign out_rs2  = rd_data[XLEN-1:0];

    assign head_is_conf = (out_inst[6:0] == V_ARITH) && (out_inst[14:12] == CONF);
    assign out_valid    = (state_q == IQ_RUN) && !empty;
    assign deq          = out_valid && out_ready;
    assign dbg_state    = state_q;

    always_comb begin
        state_d = state_q;
        if (flush) begin
            state_d = IQ_RUN;
        end else begin
            case (state_q)
                // cfg_done in this state is meaningless, even alongside a CONF issue.
                IQ_RUN: begin
                    if (deq && head_is_conf) begin
                        state_d = IQ_WAIT_CFG;
                    end
                end
                IQ_WAIT_CFG: begin
                    if (cfg_done) begin
                        state_d = IQ_RUN;
                    end
                end
                default: state_d = IQ_RUN;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IQ_RUN;
        end else begin
            state_q <= state_d;
        end
    end

endmodule
